// File: rtl/ob_ask_table.sv
// ob_ask_table: N-slot resting ask table that tracks the lowest-price entry.
// CANCEL-by-uid is built only when OB_ASK_TABLE_CANCEL_EN is defined; otherwise op 10 is BADOP.
module ob_ask_table #(
  parameter int N       = 16,
  parameter int PRICE_W = 16,
  parameter int QTY_W   = 16,
  parameter int UID_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_vld,
  input  logic [1:0]         cmd_op,
  input  logic [UID_W-1:0]   cmd_uid,
  input  logic [PRICE_W-1:0] cmd_price,
  input  logic [QTY_W-1:0]   cmd_qty,
  output logic               cmd_rdy,
  output logic               rsp_vld,
  output logic [2:0]         rsp_status,
  output logic [UID_W-1:0]   rsp_uid,
  output logic [PRICE_W-1:0] rsp_price,
  output logic [QTY_W-1:0]   rsp_qty,
  output logic               best_vld,
  output logic [UID_W-1:0]   best_uid,
  output logic [PRICE_W-1:0] best_price,
  output logic [QTY_W-1:0]   best_qty,
  output logic [$clog2(N):0] occupancy,
  output logic               o_dbg_state
);
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [2:0] ST_OK = 3'd0, ST_FULL = 3'd1, ST_EMPTY = 3'd2,
                         ST_NOTFOUND = 3'd3, ST_BADOP = 3'd4;

  typedef enum logic {S_IDLE = 1'b0, S_UPDATE = 1'b1} state_t;

  // Handshake: a command is taken on a rising edge with cmd_vld && cmd_rdy;
  // exactly one rsp_vld pulse follows in the next cycle (the UPDATE cycle).
  state_t               r_state, w_state_nxt;
  logic [N-1:0]         r_valid;
  logic [UID_W-1:0]     r_uid   [N];
  logic [PRICE_W-1:0]   r_price [N];
  logic [QTY_W-1:0]     r_qty   [N];
  logic [CNT_W-1:0]     r_occ;
  logic                 r_rsp_vld;
  logic [2:0]           r_rsp_status;
  logic [UID_W-1:0]     r_rsp_uid;
  logic [PRICE_W-1:0]   r_rsp_price;
  logic [QTY_W-1:0]     r_rsp_qty;
  logic                 r_best_vld;
  logic [IDX_W-1:0]     r_best_idx;
  logic [UID_W-1:0]     r_best_uid;
  logic [PRICE_W-1:0]   r_best_price;
  logic [QTY_W-1:0]     r_best_qty;

  logic                 w_accept;
  logic                 w_free_found, w_min_found;
  logic [IDX_W-1:0]     w_free_idx, w_min_idx, w_rm_idx;
  logic [PRICE_W-1:0]   w_min_price;
  logic                 w_do_ins, w_do_rm;
  logic [2:0]           w_status;
  logic [UID_W-1:0]     w_rsp_uid;
  logic [PRICE_W-1:0]   w_rsp_price;
  logic [QTY_W-1:0]     w_rsp_qty;

  always_comb begin
    w_state_nxt = r_state;
    cmd_rdy     = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_rdy = rst;
        if (cmd_vld && rst) w_state_nxt = S_UPDATE;
      end
      S_UPDATE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept = cmd_vld && cmd_rdy;

  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
    end
  end

  // Strict less-than keeps the lowest index on equal prices.
  always_comb begin
    w_min_found = 1'b0;
    w_min_idx   = '0;
    w_min_price = '0;
    for (int i = 0; i < N; i++) begin
      if (r_valid[i] && (!w_min_found || r_price[i] < w_min_price)) begin
        w_min_found = 1'b1;
        w_min_idx   = IDX_W'(i);
        w_min_price = r_price[i];
      end
    end
  end

`ifdef OB_ASK_TABLE_CANCEL_EN
  logic             w_cx_found;
  logic [IDX_W-1:0] w_cx_idx;
  always_comb begin
    w_cx_found = 1'b0;
    w_cx_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r_valid[i] && r_uid[i] == cmd_uid) begin
        w_cx_found = 1'b1;
        w_cx_idx   = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    w_status    = ST_BADOP;
    w_do_ins    = 1'b0;
    w_do_rm     = 1'b0;
    w_rm_idx    = '0;
    w_rsp_uid   = cmd_uid;
    w_rsp_price = cmd_price;
    w_rsp_qty   = cmd_qty;
    case (cmd_op)
      2'b00: begin
        w_status = w_free_found ? ST_OK : ST_FULL;
        w_do_ins = w_free_found;
      end
      2'b01: begin
        if (r_best_vld) begin
          w_status    = ST_OK;
          w_do_rm     = 1'b1;
          w_rm_idx    = r_best_idx;
          w_rsp_uid   = r_best_uid;
          w_rsp_price = r_best_price;
          w_rsp_qty   = r_best_qty;
        end else begin
          w_status = ST_EMPTY;
        end
      end
      2'b10: begin
`ifdef OB_ASK_TABLE_CANCEL_EN
        if (w_cx_found) begin
          w_status    = ST_OK;
          w_do_rm     = 1'b1;
          w_rm_idx    = w_cx_idx;
          w_rsp_uid   = r_uid[w_cx_idx];
          w_rsp_price = r_price[w_cx_idx];
          w_rsp_qty   = r_qty[w_cx_idx];
        end else begin
          w_status = ST_NOTFOUND;
        end
`else
        w_status = ST_BADOP;
`endif
      end
      default: w_status = ST_BADOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_occ        <= '0;
      r_rsp_vld    <= 1'b0;
      r_rsp_status <= '0;
      r_rsp_uid    <= '0;
      r_rsp_price  <= '0;
      r_rsp_qty    <= '0;
      r_best_vld   <= 1'b0;
      r_best_idx   <= '0;
      r_best_uid   <= '0;
      r_best_price <= '0;
      r_best_qty   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rsp_vld <= w_accept;
      if (w_accept) begin
        r_rsp_status <= w_status;
        r_rsp_uid    <= w_rsp_uid;
        r_rsp_price  <= w_rsp_price;
        r_rsp_qty    <= w_rsp_qty;
        if (w_do_ins) begin
          r_valid[w_free_idx] <= 1'b1;
          r_occ               <= r_occ + CNT_W'(1);
        end else if (w_do_rm) begin
          r_valid[w_rm_idx] <= 1'b0;
          r_occ             <= r_occ - CNT_W'(1);
        end
      end
      // Table already reflects the command during UPDATE; publish the new best.
      if (r_state == S_UPDATE) begin
        r_best_vld   <= w_min_found;
        r_best_idx   <= w_min_idx;
        r_best_uid   <= w_min_found ? r_uid[w_min_idx]   : '0;
        r_best_price <= w_min_found ? r_price[w_min_idx] : '0;
        r_best_qty   <= w_min_found ? r_qty[w_min_idx]   : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_accept && w_do_ins) begin
      r_uid[w_free_idx]   <= cmd_uid;
      r_price[w_free_idx] <= cmd_price;
      r_qty[w_free_idx]   <= cmd_qty;
    end
  end

  // A reset arriving in UPDATE suppresses the pending response.
  assign rsp_vld     = r_rsp_vld & rst;
  assign rsp_status  = r_rsp_status;
  assign rsp_uid     = r_rsp_uid;
  assign rsp_price   = r_rsp_price;
  assign rsp_qty     = r_rsp_qty;
  assign best_vld    = r_best_vld;
  assign best_uid    = r_best_uid;
  assign best_price  = r_best_price;
  assign best_qty    = r_best_qty;
  assign occupancy   = r_occ;
  assign o_dbg_state = r_state;
endmodule

// File: doc/ob_ask_table.md
OB_ASK_TABLE -- requirements
Module: ob_ask_table

Interface
REQ-001 Parameter N, default 16: table entries; power of two, at least 2.
REQ-002 Parameter PRICE_W, default 16: price width (unsigned).
REQ-003 Parameter QTY_W, default 16: quantity width (unsigned).
REQ-004 Parameter UID_W, default 32: order identifier width.
REQ-005 Port clk  in  1: sole clock; all state changes on its rising edge.
REQ-006 Port rst  in  1: reset; synchronous, active-low (0 = reset).
REQ-007 Port cmd_vld  in  1: command valid.
REQ-008 Port cmd_op  in  2: 00 INSERT, 01 POP (remove best ask), 10 CANCEL (by uid), 11 reserved.
REQ-009 Ports cmd_uid / cmd_price / cmd_qty  in  UID_W / PRICE_W / QTY_W: command payload.
REQ-010 Port cmd_rdy  out  1: command accepted when cmd_vld and cmd_rdy are both 1 at a rising edge.
REQ-011 Port rsp_vld  out  1: one-cycle response pulse, one per accepted command.
REQ-012 Port rsp_status  out  3: 0 OK, 1 FULL, 2 EMPTY, 3 NOTFOUND, 4 BADOP.
REQ-013 Ports rsp_uid / rsp_price / rsp_qty  out: removed entry for POP/CANCEL OK; command payload echoed otherwise.
REQ-014 Ports best_vld / best_uid / best_price / best_qty  out: current lowest-price resting ask.
REQ-015 Port occupancy  out  $clog2(N)+1: number of valid entries.

Function
REQ-016 Storage: N slots, each holding valid, uid, price and qty.
REQ-017 FSM states: IDLE (cmd_rdy=1) and UPDATE (cmd_rdy=0). An accept in IDLE goes to UPDATE; UPDATE always returns to IDLE after one cycle.
REQ-018 Throughput is one command per 2 cycles. rsp_vld is asserted in the cycle after accept, which is the UPDATE cycle.
REQ-019 INSERT writes the lowest-index free slot at the accept edge and responds OK. If the table is full, it responds FULL and leaves the table unchanged.
REQ-020 INSERT with cmd_qty=0 is accepted as a normal entry; no quantity check is made.
REQ-021 POP invalidates the slot currently reported by best_* and returns that slot's contents with OK. If best_vld=0, it responds EMPTY.
REQ-022 CANCEL invalidates the lowest-index valid slot whose uid matches, returning its contents with OK. With no match, it responds NOTFOUND.
REQ-023 Duplicate uids are not checked on INSERT.
REQ-024 Best selection picks the minimum price among valid slots; on equal prices, the lowest slot index wins.
REQ-025 best_* are registered and reloaded at the end of the UPDATE cycle, so they reflect a command 2 cycles after its accept edge. They hold their value during UPDATE.
REQ-026 best_vld=0 iff occupancy=0; best_uid/price/qty are 0 when best_vld=0.
REQ-027 occupancy updates at the accept edge: +1 on INSERT OK, -1 on POP/CANCEL OK. It never exceeds N and never goes below 0.
REQ-028 Reserved op 11 responds BADOP with no state change.
REQ-029 cmd_* inputs are ignored when cmd_rdy=0.

Reset
REQ-030 With rst=0 at a rising edge, all valid bits clear and the FSM goes to IDLE. occupancy, rsp_vld, rsp_*, best_vld and best_* all go to 0.
REQ-031 cmd_rdy=0 while rst=0, and cmd_rdy=1 in the first cycle after rst returns to 1.
REQ-032 Reset during UPDATE abandons the command: the table is empty and no rsp_vld is issued.

Configuration
REQ-033 Macro OB_ASK_TABLE_CANCEL_EN defined: CANCEL behaves per REQ-022, including the uid compare logic.
REQ-034 Macro OB_ASK_TABLE_CANCEL_EN undefined: no uid compare logic is built; op 10 responds BADOP with no state change.

Verification
REQ-035 Reset, then INSERT uids 1/2/3 at prices 100/90/95, qty 10 each.
- Expected: three OK responses and occupancy=3.
- Expected: best_uid=2, best_price=90 two cycles after the third accept.
REQ-036 From REQ-035, POP twice.
- Expected: first response OK with uid 2 / price 90; second OK with uid 3 / price 95.
- Expected: best_price=100 and occupancy=1.
REQ-037 Fill the table with N INSERTs, then one more INSERT.
- Expected: the extra INSERT responds FULL and occupancy stays N.
- Then POP N+1 times from full. Expected: the last POP responds EMPTY and best_vld=0.
REQ-038 INSERT uid 7 at price 50, then uid 8 at price 50.
- Expected: best_uid=7.
- Then CANCEL 7. Expected: OK and best_uid=8.
- Then CANCEL 99. Expected: NOTFOUND.
- With the macro undefined, CANCEL 7 responds BADOP.
REQ-039 Assert rst=0 during the UPDATE cycle of an INSERT.
- Expected: no rsp_vld, occupancy=0, best_vld=0.
- Expected: cmd_rdy=1 in the cycle after rst is released.
REQ-040 Hold cmd_vld=1 continuously with op 11.
- Expected: BADOP on every other cycle, cmd_rdy toggling 1/0, and no table change.
